// File: rtl/pipelined_carry_chain_adder.sv
// Pipelined carry-mux/XOR chain adder: resolves prop/gen into a product slice, SEG bits per stage.
// Optional carry-out port enabled by defining CLA_COUT_EN.
module pipelined_carry_chain_adder #(
    parameter int LSB   = 14,
    parameter int WIDTH = 50,
    parameter int SEG   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] prop,
    input  logic [WIDTH-1:0] gen,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product
`ifdef CLA_COUT_EN
    ,
    output logic             cout
`endif
);

    localparam int NSTG = (WIDTH + SEG - 1) / SEG;
    localparam int PW   = NSTG * SEG;

    if ((SEG % 4) != 0 || SEG < 4 || SEG > WIDTH || LSB < 0) begin : g_bad_cfg
        $error("pipelined_carry_chain_adder: illegal LSB/WIDTH/SEG combination");
    end

    // Number of live bits in segment k; only the last segment can be partial.
    function automatic int seg_bits(input int k);
        return (WIDTH - k * SEG > SEG) ? SEG : WIDTH - k * SEG;
    endfunction

    // Returns {carry_out, sum} of one segment; bits at or above nb are left 0 and do not touch the carry.
    function automatic logic [SEG:0] resolve_seg(input logic [SEG-1:0] p,
                                                 input logic [SEG-1:0] g,
                                                 input logic           c_in,
                                                 input int             nb);
        logic           c;
        logic [SEG-1:0] s;
        c = c_in;
        s = '0;
        for (int i = 0; i < SEG; i++) begin
            if (i < nb) begin
                s[i] = p[i] ^ c;
                c    = p[i] ? c : g[i];
            end
        end
        return {c, s};
    endfunction

    logic          r_vld_p  [NSTG];
    logic          r_cy_p   [NSTG];
    logic [PW-1:0] r_sum_p  [NSTG];
    logic [PW-1:0] r_prop_p [NSTG];
    logic [PW-1:0] r_gen_p  [NSTG];

    logic          w_vin [NSTG];
    logic          w_cin [NSTG];
    logic [PW-1:0] w_pin [NSTG];
    logic [PW-1:0] w_gin [NSTG];
    logic [PW-1:0] w_sin [NSTG];
    logic [PW-1:0] w_snx [NSTG];
    logic [SEG:0]  w_res [NSTG];
    logic          w_stall;

    assign w_stall   = r_vld_p[NSTG-1] && !out_ready;
    assign in_ready  = !w_stall;
    assign out_valid = r_vld_p[NSTG-1];
    assign product   = r_sum_p[NSTG-1][WIDTH-1:0];
`ifdef CLA_COUT_EN
    assign cout      = r_cy_p[NSTG-1];
`endif

    // Stage k consumes the stage k-1 registers (stage 0 the ports) and resolves segment k.
    always_comb begin
        w_vin[0] = in_valid;
        w_cin[0] = cin;
        w_pin[0] = '0;
        w_pin[0][WIDTH-1:0] = prop;
        w_gin[0] = '0;
        w_gin[0][WIDTH-1:0] = gen;
        w_sin[0] = '0;
        for (int k = 1; k < NSTG; k++) begin
            w_vin[k] = r_vld_p[k-1];
            w_cin[k] = r_cy_p[k-1];
            w_pin[k] = r_prop_p[k-1];
            w_gin[k] = r_gen_p[k-1];
            w_sin[k] = r_sum_p[k-1];
        end
        for (int k = 0; k < NSTG; k++) begin
            w_res[k] = resolve_seg(w_pin[k][k*SEG +: SEG], w_gin[k][k*SEG +: SEG],
                                   w_cin[k], seg_bits(k));
            w_snx[k] = w_sin[k];
            w_snx[k][k*SEG +: SEG] = w_res[k][SEG-1:0];
        end
    end

    // Stage registers: the whole pipe advances together or holds together.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NSTG; k++) begin
                r_vld_p[k] <= 1'b0;
                r_cy_p[k]  <= 1'b0;
                r_sum_p[k] <= '0;
            end
        end else if (!w_stall) begin
            for (int k = 0; k < NSTG; k++) begin
                r_vld_p[k] <= w_vin[k];
                r_cy_p[k]  <= w_res[k][SEG];
                r_sum_p[k] <= w_snx[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!w_stall) begin
            for (int k = 0; k < NSTG; k++) begin
                r_prop_p[k] <= w_pin[k];
                r_gen_p[k]  <= w_gin[k];
            end
        end
    end

endmodule
